// File: rtl/reg_mem_dp.sv
// reg_mem_dp: dual-port register memory with byte-lane writes, registered read and clear sweep.
// Optional feature: define REG_MEM_BYPASS_EN to forward same-address write data to the read port.
module reg_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS = 5,
    parameter int LANE_W = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_clr,
    output logic                           o_busy,
    input  logic                           i_wr_en,
    input  logic [ADDR_BITS-1:0]           i_wr_addr,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    input  logic [DATA_WIDTH/LANE_W-1:0]   i_wr_be,
    input  logic                           i_rd_en,
    input  logic [ADDR_BITS-1:0]           i_rd_addr,
    output logic [DATA_WIDTH-1:0]          o_rd_data,
    output logic                           o_rd_valid,
    output logic                           o_rej
);
    localparam int LANES = DATA_WIDTH / LANE_W;
    localparam int DEPTH = 1 << ADDR_BITS;
    typedef enum logic {CLEAR, READY} state_t;
    state_t                r_state, w_state_nxt;
    logic [ADDR_BITS-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_acc, w_wr, w_rd;
    assign o_busy = (r_state == CLEAR);
    assign w_acc  = (r_state == READY) && !i_clr;
    assign w_wr   = w_acc && i_wr_en;
    assign w_rd   = w_acc && i_rd_en;
    // sweep state and counter; reset aborts any sweep and restarts it from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    // next state: sweep until the last address is written, clr (re)starts the sweep
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        if (r_state == CLEAR) begin
            w_cnt_nxt = i_clr ? '0 : r_cnt + 1'b1;
            if (!i_clr && r_cnt == '1) w_state_nxt = READY;
        end else if (i_clr) begin
            w_state_nxt = CLEAR;
        end
    end
    // storage: sweep writes whole words, normal writes only touch enabled lanes
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) r_mem[r_cnt] <= INIT_VALUE;
        else if (w_wr)
            for (int i = 0; i < LANES; i++)
                if (i_wr_be[i]) r_mem[i_wr_addr][i*LANE_W +: LANE_W] <= i_wr_data[i*LANE_W +: LANE_W];
    end
`ifdef REG_MEM_BYPASS_EN
    // same-address read sees the word as it will be after this cycle's write
    always_comb begin
        w_rd_word = r_mem[i_rd_addr];
        if (w_wr && i_wr_addr == i_rd_addr)
            for (int i = 0; i < LANES; i++)
                if (i_wr_be[i]) w_rd_word[i*LANE_W +: LANE_W] = i_wr_data[i*LANE_W +: LANE_W];
    end
`else
    assign w_rd_word = r_mem[i_rd_addr];
`endif
    // registered read port; rd_data holds between reads, rej flags dropped requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_rej      <= 1'b0;
        end else begin
            if (w_rd) o_rd_data <= w_rd_word;
            o_rd_valid <= w_rd;
            o_rej      <= (o_busy || i_clr) && (i_wr_en || i_rd_en);
        end
    end
endmodule

// File: tb/tb_reg_mem_dp.sv
// tb_reg_mem_dp: randomized self-checking bench for reg_mem_dp (32-bit words, 4 lanes, 32 words).
module tb_reg_mem_dp;
    logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
    logic wr_en = 1'b0, rd_en = 1'b0;
    logic [4:0] wr_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0] wr_be = '0;
    logic busy, rd_valid, rej;
    logic [31:0] rd_data;
    logic [31:0] model [32];
    int errors = 0, checks = 0;

    reg_mem_dp #(.DATA_WIDTH(32), .ADDR_BITS(5), .LANE_W(8), .INIT_VALUE(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .i_clr(clr), .o_busy(busy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_rej(rej)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lmask(input logic [3:0] be);
        lmask = '0;
        for (int i = 0; i < 4; i++) if (be[i]) lmask[i*8 +: 8] = 8'hFF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        return (old & ~lmask(be)) | (d & lmask(be));
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
        model[a] = merge(model[a], d, be);
    endtask

    task automatic test_reset();
        int n;
        #2 rst_n = 1'b0;
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (rd_valid !== 1'b0 || rej !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", rd_valid, rej); end
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick(); n++;
            if (!busy) break;
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL reset_sweep_len got=%0d exp=32", n); end
        rd_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = a[4:0];
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== model[a]) begin errors++; $display("FAIL reset_read[%0d] got=%b/%h exp=1/%h", a, rd_valid, rd_data, model[a]); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_drop got=%b exp=0", rd_valid); end
    endtask

    task automatic test_byte_lanes();
        wr(5'd3, 32'hAABBCCDD, 4'hF);
        wr(5'd3, 32'h11223344, 4'b0101);
        wr(5'd3, 32'hFFFFFFFF, 4'h0);
        rd_en = 1'b1; rd_addr = 5'd3;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'hAA22CC44 || rd_valid !== 1'b1) begin errors++; $display("FAIL byte_lanes got=%h/%b exp=aa22cc44/1", rd_data, rd_valid); end
        checks++; if (rej !== 1'b0) begin errors++; $display("FAIL byte_lanes_rej got=%b exp=0", rej); end
    endtask

    task automatic test_collision();
        logic [31:0] exp;
`ifdef REG_MEM_BYPASS_EN
        exp = merge(model[7], 32'h5A, 4'h1);
`else
        exp = model[7];
`endif
        rd_en = 1'b1; rd_addr = 5'd7;
        wr(5'd7, 32'h0000005A, 4'h1);
        rd_en = 1'b0;
        checks++; if (rd_data !== exp) begin errors++; $display("FAIL collision got=%h exp=%h", rd_data, exp); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'h5A) begin errors++; $display("FAIL collision_after got=%h exp=0000005a", rd_data); end
    endtask

    task automatic test_hold();
        wr(5'd5, 32'h77, 4'hF);
        rd_en = 1'b1; rd_addr = 5'd5;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'h77 || rd_valid !== 1'b1) begin errors++; $display("FAIL hold_read got=%h/%b exp=77/1", rd_data, rd_valid); end
        for (int k = 0; k < 5; k++) begin
            rd_addr = 5'd5;
            wr(5'(10 + k), $urandom, 4'hF);
            checks++; if (rd_data !== 32'h77 || rd_valid !== 1'b0) begin errors++; $display("FAIL hold[%0d] got=%h/%b exp=77/0", k, rd_data, rd_valid); end
        end
    endtask

    task automatic test_random();
        logic [31:0] last, exp, d;
        logic [4:0] wa, ra;
        logic [3:0] be;
        logic we, re;
        last = rd_data;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom); re = 1'($urandom);
            wa = 5'($urandom); ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            d = $urandom; be = 4'($urandom);
            exp = model[ra];
`ifdef REG_MEM_BYPASS_EN
            if (we && wa == ra) exp = merge(model[ra], d, be);
`endif
            wr_en = we; wr_addr = wa; wr_data = d; wr_be = be;
            rd_en = re; rd_addr = ra;
            tick();
            if (we) model[wa] = merge(model[wa], d, be);
            if (re) last = exp;
            checks++; if (rd_valid !== re || rd_data !== last) begin errors++; $display("FAIL random[%0d] got=%b/%h exp=%b/%h", n, rd_valid, rd_data, re, last); end
            checks++; if (rej !== 1'b0) begin errors++; $display("FAIL random_rej[%0d] got=%b exp=0", n, rej); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        for (int a = 0; a < 32; a++) wr(a[4:0], 32'hFFFFFFFF, 4'hF);
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        n = 0;
        wr_addr = 5'd4; rd_addr = 5'd4; wr_data = 32'h12; wr_be = 4'hF;
        for (int k = 0; k < 100; k++) begin
            clr = (k == 0); rd_en = (k == 0 || k == 5); wr_en = (k == 2);
            tick();
            if (k == 0 || k == 2 || k == 5) begin
                checks++; if (rej !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL clear_rej[%0d] got=%b/%b exp=1/0", k, rej, rd_valid); end
            end
            if (k == 1 || k == 3) begin
                checks++; if (rej !== 1'b0) begin errors++; $display("FAIL clear_norej[%0d] got=%b exp=0", k, rej); end
            end
            if (busy) n++; else break;
        end
        clr = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        checks++; if (n !== 32) begin errors++; $display("FAIL clear_busy_len got=%0d exp=32", n); end
        rd_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = a[4:0];
            tick();
            checks++; if (rd_data !== model[a] || rd_valid !== 1'b1) begin errors++; $display("FAIL clear_read[%0d] got=%h/%b exp=%h/1", a, rd_data, rd_valid, model[a]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        wr(5'd20, 32'hDEADBEEF, 4'hF);
        wr(5'd1, 32'h12345678, 4'hF);
        rd_en = 1'b1; rd_addr = 5'd1;
        tick();
        rd_en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_data !== 32'h0 || busy !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL midreset_async got=%h/%b/%b exp=0/1/0", rd_data, busy, rd_valid); end
        tick(); tick();
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL midreset_hold got=%h exp=0", rd_data); end
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick(); n++;
            if (!busy) break;
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL midreset_sweep_len got=%0d exp=32", n); end
        rd_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = a[4:0];
            tick();
            checks++; if (rd_data !== model[a]) begin errors++; $display("FAIL midreset_read[%0d] got=%h exp=%h", a, rd_data, model[a]); end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_collision();
        test_hold();
        test_random();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
